// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the multi-channel PWM block.
//   - default WIDTH / CHANNELS / PRESCALE_W values
//   - register map offsets used by the I2C register decoder
//   - chan_w(): width of the channel select field for a given channel count
package pwm_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_PRESCALE_W = 8;

    // Global registers
    localparam logic [7:0] REG_PERIOD_LO = 8'h00;
    localparam logic [7:0] REG_PERIOD_HI = 8'h01;
    localparam logic [7:0] REG_PRESCALE  = 8'h02;

    // Per-channel register block: base + ch * stride + offset
    localparam logic [7:0] REG_CH_BASE   = 8'h10;
    localparam int         REG_CH_STRIDE = 4;

    typedef enum logic [1:0] {
        CH_DUTY_LO = 2'd0,
        CH_DUTY_HI = 2'd1,
        CH_CTRL    = 2'd2
    } ch_reg_e;

    // Bit position of the invert flag inside CHn_CTRL
    localparam int CTRL_INVERT_BIT = 0;

    function automatic logic [7:0] ch_reg_addr(input int ch, input ch_reg_e r);
        return REG_CH_BASE + 8'(ch * REG_CH_STRIDE) + 8'(r);
    endfunction

    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: register-write port of pwm_multi.
//   period_wr / period_in            : write the shadow period
//   duty_wr / duty_chan / duty_in /
//   invert_in                        : write one channel's shadow duty and polarity
// master = register decoder side, slave = PWM block side.
interface pwm_multi_if
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int CHAN_W = chan_w(CHANNELS);

    logic              period_wr;
    logic [WIDTH-1:0]  period_in;
    logic              duty_wr;
    logic [CHAN_W-1:0] duty_chan;
    logic [WIDTH-1:0]  duty_in;
    logic              invert_in;

    modport master (
        output period_wr, period_in, duty_wr, duty_chan, duty_in, invert_in
    );

    modport slave (
        input period_wr, period_in, duty_wr, duty_chan, duty_in, invert_in
    );

endinterface

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM output.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : 0 = drive the idle (inverted-inactive) level
//   load       : copy shadow duty/invert into the active registers
//   wr         : write shadow duty/invert from duty_in/invert_in
//   cnt        : shared period counter
//   out        : registered PWM output
module pwm_channel #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic             wr,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             invert_in,
    input  logic [WIDTH-1:0] cnt,
    output logic             out
);

    logic [WIDTH-1:0] shadow_duty;
    logic             shadow_inv;
    logic [WIDTH-1:0] active_duty;
    logic             active_inv;

    // NOTE: non-blocking assignments matter here: when wr and load hit the
    // same edge, active_* picks up the old shadow value and the new write
    // waits for the next boundary. Blocking would leak the new value through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_duty <= '0;
            shadow_inv  <= 1'b0;
            active_duty <= '0;
            active_inv  <= 1'b0;
            out         <= 1'b0;
        end else begin
            if (wr) begin
                shadow_duty <= duty_in;
                shadow_inv  <= invert_in;
            end
            if (load) begin
                active_duty <= shadow_duty;
                active_inv  <= shadow_inv;
            end
            // duty 0 never matches -> constant inactive; duty > period always matches
            out <= enable ? ((cnt < active_duty) ^ active_inv) : active_inv;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: edge-aligned multi-channel PWM generator.
//   clk, reset    : clock, asynchronous active-high reset
//   enable        : 1 = counters run, 0 = outputs at idle level
//   prescale      : counter advances once every prescale+1 clocks
//   bus           : register-write port (period, per-channel duty/invert)
//   out           : registered PWM outputs, one per channel
//   period_start  : one-clock pulse when the counter wraps to 0
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    pwm_multi_if.slave            bus,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_start
);

    localparam int CHAN_W = chan_w(CHANNELS);

    logic [PRESCALE_W-1:0] pcnt;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      shadow_period;
    logic [WIDTH-1:0]      active_period;
    logic                  en_q;
    logic                  tick;
    logic                  wrap;
    logic                  load;

    // >= rather than == so a prescale lowered below the running pcnt ticks at once
    assign tick = enable && (pcnt >= prescale);
    assign wrap = tick && (cnt == active_period);
    // While disabled the shadows are copied every clock so writes apply immediately
    assign load = !enable || wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt          <= '0;
            cnt           <= '0;
            shadow_period <= '0;
            active_period <= '0;
            en_q          <= 1'b0;
            period_start  <= 1'b0;
        end else begin
            en_q <= enable;
            if (bus.period_wr) begin
                shadow_period <= bus.period_in;
            end
            if (load) begin
                active_period <= shadow_period;
            end

            if (!enable || tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PRESCALE_W'(1);
            end

            if (!enable || wrap) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + WIDTH'(1);
            end

            // The first enabled cycle never reports a period start
            period_start <= wrap && en_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .load      (load),
            .wr        (bus.duty_wr && (bus.duty_chan == CHAN_W'(i))),
            .duty_in   (bus.duty_in),
            .invert_in (bus.invert_in),
            .cnt       (cnt),
            .out       (out[i])
        );
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator, the successor to the single-channel 16-bit PWM used on the unicone FPGA for LED and analog-output emulation.
- All channels share one prescaler and one programmable period counter, so they stay edge-aligned.
- Per-channel duty and polarity are written through a simple register-write port, normally driven by the I2C register decoder.
- Shadow registers make duty and period changes glitch-free by applying them only at period boundaries.

Parameters:
WIDTH, 16, bit width of period, duty and the period counter.
CHANNELS, 4, number of independent PWM outputs (1..16).
PRESCALE_W, 8, width of the clock prescaler divide value.
CHAN_W, $clog2(CHANNELS) (minimum 1), width of the channel select field; derived, not overridden.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
enable  in  1  1 = counters run; 0 = outputs idle.
prescale  in  PRESCALE_W  counter advances once every prescale+1 clocks.
period_wr  in  1  one-cycle strobe: latch period_in into the shadow period.
period_in  in  WIDTH  period value; the counter runs 0..period inclusive.
duty_wr  in  1  one-cycle strobe: write the shadow duty and invert bit of channel duty_chan.
duty_chan  in  CHAN_W  target channel; values >= CHANNELS are ignored.
duty_in  in  WIDTH  duty value, in counts of high time.
invert_in  in  1  output polarity for the channel; takes effect at the same time as its duty.
out  out  CHANNELS  registered PWM outputs.
period_start  out  1  one-clock pulse when the counter wraps to 0 (shadow load point).

Behaviour:
Reset:
- Counter, prescaler, all shadow and active registers are cleared.
- Active period = 0; out = 0; period_start = 0.

Prescaler:
- pcnt counts 0..prescale. tick = (pcnt == prescale).
- On tick, pcnt returns to 0.
- prescale = 0 gives tick every clock.
- A change of prescale mid-count takes effect immediately. If pcnt > prescale, tick is asserted and pcnt wraps to 0.

Period counter:
- cnt advances on tick.
- When cnt == active_period and tick: cnt <= 0, period_start pulses for one clock, and the load event occurs.
- Active period 0: cnt stays at 0 and the load event occurs on every tick.

Load event:
- active_period <= shadow_period.
- For each channel: active_duty[i] <= shadow_duty[i] and active_inv[i] <= shadow_inv[i].

Shadow writes:
- Registered on the cycle of the strobe.
- If a write coincides with a load event, the active copy receives the pre-write shadow value. The new value applies at the next boundary.

Output:
- out[i] <= (cnt < active_duty[i]) XOR active_inv[i], registered, so latency is 1 clock from the cnt value.
- duty 0 gives 0 % (constant inactive level).
- duty > active_period gives 100 %.
- High time per period = min(duty, period+1) counts of (prescale+1) clocks.

Disable (enable = 0):
- cnt and pcnt are held at 0; period_start = 0.
- Shadow-to-active copy happens every clock, so writes apply immediately.
- out[i] <= active_inv[i] (idle level).
- On enable rising: counting starts from cnt = 0 with current values, and no period_start pulse occurs for that first cycle.

Reset mid-operation:
- Asynchronous. Everything clears immediately, including shadows; software must rewrite them afterwards.

Widths:
- All comparisons are unsigned WIDTH-bit.
- Every counter increment wraps inside its own width.

Decomposition:
Shared package pwm_pkg holds:
- Default WIDTH, CHANNELS and PRESCALE_W constants.
- The I2C register map offsets used by the decoder: PERIOD_LO/HI, PRESCALE, CHn_DUTY_LO/HI, CHn_CTRL (bit0 = invert).

One natural sub-module, pwm_channel:
- Holds the shadow and active duty/invert registers and the output compare flop.
- Instantiated CHANNELS times in a generate loop.
- The top holds the prescaler, period counter and load logic.

Test Plan:
- Basic duty: WIDTH=16, prescale=0, period=9, ch0 duty=3 -> out[0] high 3 clocks, low 7, repeating every 10 clocks; period_start every 10th clock.
- Extremes: duty=0 -> out constant 0. Duty=10 with period=9 -> constant 1. Invert=1 with duty=0 -> constant 1.
- Shadowing: change ch1 duty 2->7 mid-period (cnt=4) -> current period keeps 2 high clocks, next period 7. A write on the same cycle as period_start is deferred one period.
- Prescaler: prescale=3, period=4, duty=2 -> period_start every 20 clocks, out high 8 clocks. Change prescale 3->1 while pcnt=3 -> immediate tick, then tick every 2 clocks.
- Enable/disable: deassert enable mid-period -> out at idle level next clock, cnt=0. Write duty while disabled -> first period after re-enable uses it; no period_start on the first cycle.
- Reset and channel range: assert reset asynchronously between edges -> out=0 before the next clock edge. CHANNELS=3, write duty_chan=3 -> no channel changes.
